imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Program loader: the write side of instruction memory. Receives a framed byte stream,
//  assembles 16-bit instruction words and drives the IM write port at consecutive addresses.
//  Holds the CPU halted (cpu_hold) until a complete image is written, then releases it
//  so fetch starts from BASE_ADDR.
// PARAMETERS
//  BASE_ADDR  16'h0000  IM address of the first loaded word
//  MAX_WORDS  4096      largest accepted word count; a larger header count -> error
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   1-cycle pulse: begin a load (honoured in IDLE, DONE, ERR only)
//  rx_byte    in   8   stream byte
//  rx_valid   in   1   rx_byte valid
//  rx_ready   out  1   loader accepts a byte; transfer = rx_valid & rx_ready
//  wr_en      out  1   IM write strobe, 1 cycle per word
//  wr_addr    out  16  IM write address
//  wr_data    out  16  IM write data
//  cpu_hold   out  1   1 = keep PC/fetch halted
//  done       out  1   image loaded, level
//  err        out  1   load failed, level
// BEHAVIOUR
//  Reset: state IDLE, rx_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, err=0.
//  Frame: CNT_HI, CNT_LO (16-bit word count N, big-endian), then N x {DAT_HI, DAT_LO} bytes, MSB first.
//  States: IDLE -start-> CNT_HI -> CNT_LO -> (N==0 ? DONE : N>MAX_WORDS ? ERR : DAT_HI)
//    DAT_HI -> DAT_LO -> (last word ? DONE : DAT_HI). Each arrow past IDLE consumes one transfer.
//  rx_ready=1 exactly in CNT_HI, CNT_LO, DAT_HI, DAT_LO (and CHK with option); 0 elsewhere.
//  No transfer -> state holds; rx_valid without rx_ready is ignored.
//  Write: byte accepted in DAT_LO -> next cycle wr_en=1, wr_data={hi,lo}, wr_addr=BASE_ADDR+idx;
//    idx increments after each write; wr_addr is 16-bit and wraps modulo 2^16.
//  Word index counter: 16 bits, cleared on start; last word when idx==N-1.
//  DONE: done=1, cpu_hold=0, entered the cycle after the final wr_en (never overlapping it).
//  ERR: err=1, cpu_hold=1, done=0; no further writes.
//  start in DONE/ERR: restarts at CNT_HI, clears done/err, reasserts cpu_hold same edge.
//  start in any busy state: ignored. rst_n low mid-load: immediate return to reset values;
//    partially written IM contents are not undone.
// CONFIGURATION
//  LOADER_CHKSUM_EN defined: after last data byte (or CNT_LO when N==0) enter CHK; one more byte
//    accepted; must equal XOR of all preceding frame bytes incl. count bytes; match -> DONE, else ERR.
//    Words are still written as they arrive; mismatch only blocks release of cpu_hold.
//  Not defined: no CHK state; DAT_LO of last word (or N==0) goes straight to DONE.
// STRUCTURE
//  Shared package: state encoding typedef (IDLE,CNT_HI,CNT_LO,DAT_HI,DAT_LO,CHK,DONE,ERR),
//    IM address/data width constants (16), frame byte width (8).
//  Single module; no sub-module needed: FSM, byte register, index counter, checksum register.
// TESTING
//  1 start; bytes 00 02 12 34 AB CD -> wr_en @BASE_ADDR data 1234, @BASE_ADDR+1 data ABCD; done=1, cpu_hold=0.
//  2 start; bytes 00 00 -> no wr_en, done=1 the cycle after CNT_LO transfer.
//  3 count 10 01 with MAX_WORDS=4096 -> err=1, cpu_hold=1, rx_ready=0, no writes.
//  4 rx_valid toggled randomly during 3-word load -> exactly 3 writes, data/order unchanged.
//  5 rst_n low after first word written -> all outputs at reset values next; start reloads cleanly.
//  6 LOADER_CHKSUM_EN: 00 01 12 34 then 27 -> done; then 26 -> err=1, cpu_hold stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Holds the loader state encoding and the IM / stream width constants.
package imem_loader_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DAT_HI,
        DAT_LO,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Program loader: write side of instruction memory.
// Accepts a framed byte stream (16-bit big-endian word count followed by
// big-endian 16-bit words), writes each word to consecutive IM addresses
// starting at BASE_ADDR, and keeps the CPU halted until the image is complete.
// Optional feature macro: LOADER_CHKSUM_EN adds a trailing XOR checksum byte
// that must match before the CPU is released.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int                MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    state_t              state;
    logic [BYTE_W-1:0]   cnt_hi;
    logic [BYTE_W-1:0]   dat_hi;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   last_idx;
    logic [ADDR_W-1:0]   frame_count;
    logic                xfer;
    logic                restart;
`ifdef LOADER_CHKSUM_EN
    logic [BYTE_W-1:0]   chk;
`endif

    assign xfer        = rx_valid & rx_ready;
    assign frame_count = {cnt_hi, rx_byte};
    assign restart     = start & ((state == IDLE) | (state == DONE) | (state == ERR));

    // Loader FSM with registered outputs; a finished image raises done one
    // cycle after the final write strobe so the two never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= BASE_ADDR;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cnt_hi   <= '0;
            dat_hi   <= '0;
            idx      <= '0;
            last_idx <= '0;
`ifdef LOADER_CHKSUM_EN
            chk      <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                state    <= CNT_HI;
                rx_ready <= 1'b1;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
                idx      <= '0;
`ifdef LOADER_CHKSUM_EN
                chk      <= '0;
`endif
            end else if (xfer) begin
`ifdef LOADER_CHKSUM_EN
                chk <= chk ^ rx_byte;
`endif
                case (state)
                    CNT_HI: begin
                        cnt_hi <= rx_byte;
                        state  <= CNT_LO;
                    end
                    CNT_LO: begin
                        last_idx <= frame_count - 16'd1;
                        if (frame_count == '0) begin
`ifdef LOADER_CHKSUM_EN
                            state    <= CHK;
`else
                            state    <= DONE;
                            rx_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else if ({16'h0000, frame_count} > MAX_WORDS_W) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= DAT_HI;
                        end
                    end
                    DAT_HI: begin
                        dat_hi <= rx_byte;
                        state  <= DAT_LO;
                    end
                    DAT_LO: begin
                        wr_en   <= 1'b1;
                        wr_data <= {dat_hi, rx_byte};
                        wr_addr <= BASE_ADDR + idx;
                        idx     <= idx + 16'd1;
                        if (idx == last_idx) begin
`ifdef LOADER_CHKSUM_EN
                            state    <= CHK;
`else
                            state    <= DONE;
                            rx_ready <= 1'b0;
`endif
                        end else begin
                            state <= DAT_HI;
                        end
                    end
`ifdef LOADER_CHKSUM_EN
                    CHK: begin
                        rx_ready <= 1'b0;
                        if (rx_byte == chk) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state <= state;
                    end
                endcase
            end else if ((state == DONE) && !done) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
        end
    end

endmodule
